// File: rtl/i2c_pkg.sv
// Shared types and widths for the I2C target receive path.
package i2c_pkg;

    localparam int I2C_BYTE_W = 8;
    localparam int I2C_ADDR_W = 7;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        DATA,
        DATA_ACK,
        IGNORE
    } rx_state_t;

endpackage

// File: rtl/i2c_sync_edge.sv
// Pin synchroniser followed by a one-flop edge detector producing single-cycle
// rise/fall pulses.
module i2c_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic pin_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // Reset to the idle-high bus level so leaving reset never fakes an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], pin_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level_o = sync_q[STAGES-1];
    assign rise_o  = sync_q[STAGES-1] & ~prev_q;
    assign fall_o  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/i2c_target_rx.sv
// I2C target receive path: START/STOP detection, address match with ACK and
// MSB-first byte deserialisation handed out over valid/ready.
//
// state    | meaning
// IDLE     | bus free or not for us; wait for START
// ADDR     | shifting address byte (7-bit address + R/W)
// ADDR_ACK | pulling SDA low for the address ACK bit
// DATA     | shifting a data byte
// DATA_ACK | ACK (or NACK on overrun) bit of a data byte
// IGNORE   | addressed elsewhere or read; wait for START/STOP
module i2c_target_rx
    import i2c_pkg::*;
#(
    parameter int                    N           = I2C_BYTE_W,
    parameter logic [I2C_ADDR_W-1:0] TARGET_ADDR = 7'h50,
    parameter int                    SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         scl_in,
    input  logic         sda_in,
    output logic         sda_oe,
    output logic [N-1:0] rx_data,
    output logic         rx_valid,
    input  logic         rx_ready,
    output logic         rx_first,
    output logic         busy,
    output logic         overrun
);

    localparam int CW = $clog2(N) + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    logic scl_lvl, sclr, sclf;
    logic sda_lvl, sdar, sdaf;
    logic start_ev, stop_ev;

    i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_scl (
        .clk    (clk),
        .rst    (rst),
        .pin_i  (scl_in),
        .level_o(scl_lvl),
        .rise_o (sclr),
        .fall_o (sclf)
    );

    i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_sda (
        .clk    (clk),
        .rst    (rst),
        .pin_i  (sda_in),
        .level_o(sda_lvl),
        .rise_o (sdar),
        .fall_o (sdaf)
    );

    assign start_ev = sdaf & scl_lvl;
    assign stop_ev  = sdar & scl_lvl;

    rx_state_t      state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   shift_q, shift_d;
    logic [N-1:0]   rx_data_q, rx_data_d;
    logic           rx_valid_q, rx_valid_d;
    logic           rx_first_q, rx_first_d;
    logic           pend_q, pend_d;
    logic           busy_q, busy_d;
    logic           overrun_q, overrun_d;
    logic           sda_oe_q, sda_oe_d;
    logic           ack_q, ack_d;
    logic           load_q, load_d;
    logic           can_load;
    logic           ack_now;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            shift_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_first_q <= 1'b0;
            pend_q     <= 1'b0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
            sda_oe_q   <= 1'b0;
            ack_q      <= 1'b0;
            load_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_first_q <= rx_first_d;
            pend_q     <= pend_d;
            busy_q     <= busy_d;
            overrun_q  <= overrun_d;
            sda_oe_q   <= sda_oe_d;
            ack_q      <= ack_d;
            load_q     <= load_d;
        end
    end

    // A byte may be loaded when the holding register is empty or is being
    // handed off in this very cycle.
    assign can_load = ~rx_valid_q | rx_ready;
    assign ack_now  = load_q ? can_load : ack_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        rx_first_d = rx_first_q;
        pend_d     = pend_q;
        busy_d     = busy_q;
        overrun_d  = overrun_q;
        sda_oe_d   = sda_oe_q;
        ack_d      = ack_q;
        load_d     = 1'b0;

        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
            rx_first_d = 1'b0;
        end

        if (stop_ev) begin
            state_d  = IDLE;
            cnt_d    = '0;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
            pend_d   = 1'b0;
        end else if (start_ev) begin
            state_d  = ADDR;
            cnt_d    = '0;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
            pend_d   = 1'b0;
        end else begin
            if (load_q) begin
                if (can_load) begin
                    rx_data_d  = shift_q;
                    rx_valid_d = 1'b1;
                    rx_first_d = pend_q;
                    pend_d     = 1'b0;
                    ack_d      = 1'b1;
                end else begin
                    overrun_d  = 1'b1;
                    ack_d      = 1'b0;
                end
            end

            unique case (state_q)
                IDLE: ;
                ADDR: begin
                    if (sclr && cnt_q < CNT_FULL) begin
                        shift_d = {shift_q[N-2:0], sda_lvl};
                        cnt_d   = cnt_q + 1'b1;
                    end else if (sclf && cnt_q == CNT_FULL) begin
                        if (shift_q == {TARGET_ADDR, 1'b0}) begin
                            state_d  = ADDR_ACK;
                            sda_oe_d = 1'b1;
                            busy_d   = 1'b1;
                            pend_d   = 1'b1;
                        end else begin
                            state_d  = IGNORE;
                            sda_oe_d = 1'b0;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (sclf) begin
                        state_d  = DATA;
                        sda_oe_d = 1'b0;
                        cnt_d    = '0;
                    end
                end
                DATA: begin
                    if (sclr && cnt_q < CNT_FULL) begin
                        shift_d = {shift_q[N-2:0], sda_lvl};
                        cnt_d   = cnt_q + 1'b1;
                        load_d  = (cnt_q == CNT_LAST);
                    end else if (sclf && cnt_q == CNT_FULL) begin
                        state_d  = DATA_ACK;
                        sda_oe_d = ack_now;
                    end
                end
                DATA_ACK: begin
                    if (sclf) begin
                        state_d  = DATA;
                        sda_oe_d = 1'b0;
                        cnt_d    = '0;
                    end
                end
                IGNORE: sda_oe_d = 1'b0;
                default: state_d = IDLE;
            endcase
        end
    end

    assign sda_oe   = sda_oe_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign rx_first = rx_first_q;
    assign busy     = busy_q;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_i2c_target_rx.sv
// Bit-banged I2C controller driving i2c_target_rx; received bytes are checked
// by a scoreboard monitor on the valid/ready handshake.
module tb_i2c_target_rx;

    localparam int Q = 6;

    logic       clk = 1'b0;
    logic       rst;
    logic       scl_drv, sda_drv;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       rx_first;
    logic       busy;
    logic       overrun;

    int total = 0;
    int bad   = 0;
    logic oe_seen;
    logic [8:0] exp_q[$];

    always #5 clk = ~clk;

    i2c_target_rx dut (
        .clk     (clk),
        .rst     (rst),
        .scl_in  (scl_drv),
        .sda_in  (sda_drv),
        .sda_oe  (sda_oe),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .rx_first(rx_first),
        .busy    (busy),
        .overrun (overrun)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every handshake must match the oldest expected byte.
    always @(negedge clk) begin
        if (!rst && rx_valid && rx_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_byte", {23'd0, rx_first, rx_data}, 32'h1ff);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                chk("rx_byte", {23'd0, rx_first, rx_data}, {23'd0, e});
            end
        end
        if (sda_oe) oe_seen = 1'b1;
    end

    task automatic wq();
        repeat (Q) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_drv = 1'b1; wq();
        scl_drv = 1'b1; wq();
        sda_drv = 1'b0; wq();
        scl_drv = 1'b0; wq();
    endtask

    task automatic i2c_stop();
        sda_drv = 1'b0; wq();
        scl_drv = 1'b1; wq();
        sda_drv = 1'b1; wq();
    endtask

    task automatic send_bit(input logic b);
        sda_drv = b;    wq();
        scl_drv = 1'b1; wq();
        scl_drv = 1'b0; wq();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic exp_ack, input string name);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        sda_drv = 1'b1; wq();
        scl_drv = 1'b1; wq();
        chk(name, {31'd0, sda_oe}, {31'd0, exp_ack});
        scl_drv = 1'b0; wq();
    endtask

    task automatic wait_oe();
        for (int i = 0; i < 100 && !sda_oe; i++) @(negedge clk);
        chk("oe_rise_timeout", {31'd0, sda_oe}, 32'd1);
    endtask

    initial begin
        rst = 1'b1; scl_drv = 1'b1; sda_drv = 1'b1; rx_ready = 1'b1; oe_seen = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {16'd0, sda_oe, rx_valid, rx_first, busy, overrun, 3'd0, rx_data},
            32'd0);
        rst = 1'b0;
        wq();

        // 1: write 0xA5 to 0x50
        i2c_start();
        send_byte(8'hA0, 1'b1, "t1_addr_ack");
        chk("t1_busy", {31'd0, busy}, 32'd1);
        exp_q.push_back({1'b1, 8'hA5});
        send_byte(8'hA5, 1'b1, "t1_data_ack");
        i2c_stop(); wq();
        chk("t1_busy_after_stop", {31'd0, busy}, 32'd0);

        // 2: wrong address, then read bit
        oe_seen = 1'b0;
        i2c_start();
        send_byte(8'hA2, 1'b0, "t2_addr51_nack");
        send_byte(8'h33, 1'b0, "t2_data_nack");
        i2c_stop(); wq();
        i2c_start();
        send_byte(8'hA1, 1'b0, "t2_read_nack");
        send_byte(8'h44, 1'b0, "t2_data2_nack");
        i2c_stop(); wq();
        chk("t2_oe_never", {31'd0, oe_seen}, 32'd0);
        chk("t2_busy", {31'd0, busy}, 32'd0);

        // 3: consumer stalled -> second byte overruns
        rx_ready = 1'b0;
        i2c_start();
        send_byte(8'hA0, 1'b1, "t3_addr_ack");
        exp_q.push_back({1'b1, 8'h11});
        send_byte(8'h11, 1'b1, "t3_b1_ack");
        send_byte(8'h22, 1'b0, "t3_b2_nack");
        chk("t3_overrun", {31'd0, overrun}, 32'd1);
        chk("t3_held", {23'd0, rx_valid, rx_data}, {23'd0, 1'b1, 8'h11});
        chk("t3_first", {31'd0, rx_first}, 32'd1);
        i2c_stop(); wq();
        chk("t3_valid_survives_stop", {31'd0, rx_valid}, 32'd1);
        rx_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("t3_drained", {30'd0, rx_valid, rx_first}, 32'd0);
        chk("t3_overrun_sticky", {31'd0, overrun}, 32'd1);

        // 4: repeated START mid-byte
        i2c_start();
        send_byte(8'hA0, 1'b1, "t4_addr_ack");
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        i2c_start();
        chk("t4_busy_rs", {31'd0, busy}, 32'd0);
        send_byte(8'hA0, 1'b1, "t4_addr2_ack");
        exp_q.push_back({1'b1, 8'h3C});
        send_byte(8'h3C, 1'b1, "t4_3c_ack");
        exp_q.push_back({1'b0, 8'h7E});
        send_byte(8'h7E, 1'b1, "t4_7e_ack");
        i2c_stop(); wq();

        // 5: reset while ACKing the address
        i2c_start();
        for (int i = 7; i >= 0; i--) send_bit(i == 7 || i == 5);
        wait_oe();
        rst = 1'b1;
        @(posedge clk); #1;
        chk("t5_after_rst", {27'd0, sda_oe, rx_valid, busy, overrun, rx_first}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        oe_seen = 1'b0;
        scl_drv = 1'b1; wq();
        scl_drv = 1'b0; wq();
        for (int i = 7; i >= 0; i--) send_bit(i[0]);
        send_bit(1'b1);
        chk("t5_ignored", {30'd0, oe_seen, busy}, 32'd0);
        i2c_stop(); wq();

        // 6: STOP mid-byte, and STOP during the address ACK
        i2c_start();
        send_byte(8'hA0, 1'b1, "t6_addr_ack");
        for (int i = 0; i < 3; i++) send_bit(1'b0);
        i2c_stop(); wq();
        chk("t6_mid_stop", {30'd0, busy, sda_oe}, 32'd0);
        i2c_start();
        for (int i = 7; i >= 0; i--) send_bit(i == 7 || i == 5);
        wait_oe();
        chk("t6_busy_in_ack", {31'd0, busy}, 32'd1);
        i2c_stop(); wq();
        chk("t6_ack_stop", {30'd0, busy, sda_oe}, 32'd0);
        repeat (5) @(negedge clk);
        chk("t6_no_valid", {31'd0, rx_valid}, 32'd0);

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
